// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller.
// Contents: FSM state enum, BCD field limits, field-select encodings
// (matching the H_M load-target output) and the BCD-to-DI packing helper.
package time_set_pkg;

   localparam int unsigned BCD_W = 8;
   localparam int unsigned DI_W  = 7;
   localparam int unsigned QHM_W = 16;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_SET_H,
      ST_SET_M,
      ST_LOAD_WAIT_H,
      ST_LOAD_WAIT_M
   } tsc_state_e;

   localparam logic [BCD_W-1:0] HOURS_MAX   = 8'h23;
   localparam logic [BCD_W-1:0] MINUTES_MAX = 8'h59;

   localparam logic SEL_H = 1'b0;
   localparam logic SEL_M = 1'b1;

   // Tens digit bit 3 is always 0 for valid hours/minutes, so it is dropped.
   function automatic logic [DI_W-1:0] bcd_to_di(input logic [BCD_W-1:0] v);
      return v[DI_W-1:0];
   endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Front-panel / counter-load bundle for time_set_ctrl.
// master : the controller (buttons and QHM in; DI, L, H_M, ce_en, blink flags out).
// slave  : the environment (button source, BCD counter and display driver).
// Macro TSC_DOWN_EN adds the btn_dn pulse.
interface time_set_ctrl_if;
   import time_set_pkg::*;

   logic             btn_mode;
   logic             btn_up;
`ifdef TSC_DOWN_EN
   logic             btn_dn;
`endif
   logic [QHM_W-1:0] QHM;
   logic [DI_W-1:0]  DI;
   logic             L;
   logic             H_M;
   logic             ce_en;
   logic             blink_h;
   logic             blink_m;

`ifdef TSC_DOWN_EN
   modport master (
      input  btn_mode, btn_up, btn_dn, QHM,
      output DI, L, H_M, ce_en, blink_h, blink_m
   );
   modport slave (
      output btn_mode, btn_up, btn_dn, QHM,
      input  DI, L, H_M, ce_en, blink_h, blink_m
   );
`else
   modport master (
      input  btn_mode, btn_up, QHM,
      output DI, L, H_M, ce_en, blink_h, blink_m
   );
   modport slave (
      output btn_mode, btn_up, QHM,
      input  DI, L, H_M, ce_en, blink_h, blink_m
   );
`endif

endinterface

// File: rtl/time_set_ctrl_bcd_step.sv
// bcd_step: combinational one-step BCD increment/decrement with wrap.
// Ports: val_i  - current 2-digit BCD value
//        max_i  - largest legal value (8'h23 hours, 8'h59 minutes)
//        up_i   - 1 = increment, 0 = decrement
//        next_c - wrapped next value; an invalid input steps up to 00, down to max_i
module bcd_step
   import time_set_pkg::*;
(
   input  logic [BCD_W-1:0] val_i,
   input  logic [BCD_W-1:0] max_i,
   input  logic             up_i,
   output logic [BCD_W-1:0] next_c
);

   logic [3:0] tens;
   logic [3:0] ones;
   logic       valid;

   assign tens  = val_i[7:4];
   assign ones  = val_i[3:0];
   // With a valid ones digit, plain binary compare orders BCD values correctly.
   assign valid = (ones <= 4'd9) && (val_i <= max_i);

   always_comb begin
      next_c = 8'h00;
      if (up_i) begin
         if (!valid || (val_i == max_i)) begin
            next_c = 8'h00;
         end else if (ones == 4'd9) begin
            next_c = {tens + 4'd1, 4'd0};
         end else begin
            next_c = {tens, ones + 4'd1};
         end
      end else begin
         if (!valid || (val_i == 8'h00)) begin
            next_c = max_i;
         end else if (ones == 4'd0) begin
            next_c = {tens - 4'd1, 4'd9};
         end else begin
            next_c = {tens, ones - 4'd1};
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven hours/minutes setting controller for a BCD clock counter.
// Parameters: BLINK_DIV   - clk cycles per blink half-period
//             TIMEOUT_CYC - idle cycles in a set state before returning to RUN
// Ports: clk, rst (synchronous, active high)
//        bus (time_set_ctrl_if.master): btn_mode/btn_up[/btn_dn], QHM in;
//        DI, L, H_M, ce_en, blink_h, blink_m out (all registered).
// Macro TSC_DOWN_EN enables btn_dn and decrement; otherwise increment only.
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int unsigned BLINK_DIV   = 25_000_000,
   parameter int unsigned TIMEOUT_CYC = 500_000_000
)(
   input  logic             clk,
   input  logic             rst,
   time_set_ctrl_if.master  bus
);

   localparam int unsigned BLINK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;
   localparam int unsigned IDLE_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);

   tsc_state_e         state_q, state_d;
   logic [DI_W-1:0]    di_q, di_d;
   logic               l_q, l_d;
   logic               h_m_q, h_m_d;
   logic               ce_en_q, ce_en_d;
   logic               blink_h_q, blink_h_d;
   logic               blink_m_q, blink_m_d;
   logic               phase_q, phase_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

   logic               btn_dn_c;
   logic               step_req_c;
   logic               step_up_c;
   logic               in_wait_c;
   logic               in_set_c;
   logic               btn_evt_c;
   logic               timeout_c;
   logic [BCD_W-1:0]   field_val_c;
   logic [BCD_W-1:0]   field_max_c;
   logic [BCD_W-1:0]   field_next_c;

`ifdef TSC_DOWN_EN
   assign btn_dn_c = bus.btn_dn;
`else
   assign btn_dn_c = 1'b0;
`endif

   // Up wins over down; without a down button the direction is always up.
   assign step_req_c = bus.btn_up | btn_dn_c;
   assign step_up_c  = bus.btn_up | ~btn_dn_c;

   assign in_wait_c = (state_q == ST_LOAD_WAIT_H) || (state_q == ST_LOAD_WAIT_M);
   assign in_set_c  = (state_q == ST_SET_H) || (state_q == ST_SET_M);
   // Buttons during the load-wait cycle are ignored entirely.
   assign btn_evt_c = !in_wait_c && (bus.btn_mode | step_req_c);
   assign timeout_c = (idle_cnt_q == IDLE_LAST);

   // Single stepper shared by both fields.
   assign field_val_c = (state_q == ST_SET_M) ? bus.QHM[7:0] : bus.QHM[15:8];
   assign field_max_c = (state_q == ST_SET_M) ? MINUTES_MAX  : HOURS_MAX;

   bcd_step u_bcd_step (
      .val_i  (field_val_c),
      .max_i  (field_max_c),
      .up_i   (step_up_c),
      .next_c (field_next_c)
   );

   // Next-state, load and timer logic.
   always_comb begin
      state_d     = state_q;
      di_d        = di_q;
      l_d         = 1'b0;
      h_m_d       = h_m_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      idle_cnt_d  = idle_cnt_q;

      unique case (state_q)
         ST_RUN: begin
            if (bus.btn_mode) state_d = ST_SET_H;
         end
         ST_SET_H: begin
            if (bus.btn_mode) begin
               state_d = ST_SET_M;
            end else if (step_req_c) begin
               di_d    = bcd_to_di(field_next_c);
               l_d     = 1'b1;
               h_m_d   = SEL_H;
               state_d = ST_LOAD_WAIT_H;
            end else if (timeout_c) begin
               state_d = ST_RUN;
            end
         end
         ST_SET_M: begin
            if (bus.btn_mode) begin
               state_d = ST_RUN;
            end else if (step_req_c) begin
               di_d    = bcd_to_di(field_next_c);
               l_d     = 1'b1;
               h_m_d   = SEL_M;
               state_d = ST_LOAD_WAIT_M;
            end else if (timeout_c) begin
               state_d = ST_RUN;
            end
         end
         ST_LOAD_WAIT_H: state_d = ST_SET_H;
         ST_LOAD_WAIT_M: state_d = ST_SET_M;
         default:        state_d = ST_RUN;
      endcase

      // Blink restarts on a press so the field is shown immediately.
      if (btn_evt_c) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end

      // Idle counter only advances while sitting in a set state without presses.
      if (btn_evt_c || !in_set_c || (state_d != state_q)) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end

      ce_en_d   = (state_d == ST_RUN);
      blink_h_d = phase_d && ((state_d == ST_SET_H) || (state_d == ST_LOAD_WAIT_H));
      blink_m_d = phase_d && ((state_d == ST_SET_M) || (state_d == ST_LOAD_WAIT_M));
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         di_q        <= '0;
         l_q         <= 1'b0;
         h_m_q       <= SEL_H;
         ce_en_q     <= 1'b1;
         blink_h_q   <= 1'b0;
         blink_m_q   <= 1'b0;
         phase_q     <= 1'b0;
         blink_cnt_q <= '0;
         idle_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         di_q        <= di_d;
         l_q         <= l_d;
         h_m_q       <= h_m_d;
         ce_en_q     <= ce_en_d;
         blink_h_q   <= blink_h_d;
         blink_m_q   <= blink_m_d;
         phase_q     <= phase_d;
         blink_cnt_q <= blink_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   assign bus.DI      = di_q;
   assign bus.L       = l_q;
   assign bus.H_M     = h_m_q;
   assign bus.ce_en   = ce_en_q;
   assign bus.blink_h = blink_h_q;
   assign bus.blink_m = blink_m_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with short blink/timeout periods.
module tb_time_set_ctrl;

   localparam int unsigned BLINK_DIV   = 4;
   localparam int unsigned TIMEOUT_CYC = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   time_set_ctrl_if bus_if ();

   time_set_ctrl #(
      .BLINK_DIV   (BLINK_DIV),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int mode_m = 0;   // 0 RUN, 1 setting hours, 2 setting minutes

   // Decimal reference for one BCD step of a field of modulus 24 or 60.
   function automatic logic [7:0] ref_step(input logic [7:0] v, input bit hours, input bit up);
      int hi, lo, m, n;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      m  = hours ? 24 : 60;
      n  = hi * 10 + lo;
      if (lo > 9 || n >= m) n = up ? m - 1 : 0;
      n = up ? (n + 1) % m : (n + m - 1) % m;
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic clear_buttons;
      bus_if.btn_mode = 1'b0;
      bus_if.btn_up   = 1'b0;
`ifdef TSC_DOWN_EN
      bus_if.btn_dn   = 1'b0;
`endif
   endtask

   task automatic pulse_mode;
      logic exp_ce;
      @(negedge clk);
      bus_if.btn_mode = 1'b1;
      @(negedge clk);
      bus_if.btn_mode = 1'b0;
      mode_m = (mode_m + 1) % 3;
      exp_ce = (mode_m == 0);
      n_chk++;
      if (bus_if.ce_en !== exp_ce) begin
         n_fail++;
         $display("FAIL mode_ce: ce_en=%b want %b (mode %0d)", bus_if.ce_en, exp_ce, mode_m);
      end
   endtask

   task automatic goto_mode(input int m);
      for (int i = 0; i < 3; i++) begin
         if (mode_m != m) pulse_mode();
      end
   endtask

   // One step press in the current set mode; checks the load pulse and its payload.
   task automatic press_step(input logic [7:0] v, input bit up, input string tag);
      logic [7:0] exp;
      bit         hours;
      logic       exp_hm;
      logic       blink_f;
      hours  = (mode_m == 1);
      exp    = ref_step(v, hours, up);
      exp_hm = hours ? 1'b0 : 1'b1;
      @(negedge clk);
      bus_if.QHM = hours ? {v, 8'($urandom)} : {8'($urandom), v};
      if (up) bus_if.btn_up = 1'b1;
`ifdef TSC_DOWN_EN
      else    bus_if.btn_dn = 1'b1;
`endif
      @(negedge clk);
      clear_buttons();
      blink_f = hours ? bus_if.blink_h : bus_if.blink_m;
      n_chk += 4;
      if (bus_if.L !== 1'b1) begin
         n_fail++;
         $display("FAIL %s L: got %b want 1", tag, bus_if.L);
      end
      if (bus_if.H_M !== exp_hm) begin
         n_fail++;
         $display("FAIL %s H_M: got %b want %b", tag, bus_if.H_M, exp_hm);
      end
      if (bus_if.DI !== exp[6:0]) begin
         n_fail++;
         $display("FAIL %s DI: in %h up %0d got %h want %h", tag, v, up, bus_if.DI, exp[6:0]);
      end
      if (blink_f !== 1'b0) begin
         n_fail++;
         $display("FAIL %s blink after press: got %b want 0", tag, blink_f);
      end
      @(negedge clk);
      n_chk++;
      if (bus_if.L !== 1'b0) begin
         n_fail++;
         $display("FAIL %s L width: got %b want 0", tag, bus_if.L);
      end
   endtask

   function automatic logic [7:0] rand_field(input bit hours);
      int n;
      logic [7:0] r;
      if ($urandom_range(0, 3) == 0) begin
         r = 8'($urandom);
         return r;
      end
      n = hours ? int'($urandom_range(0, 23)) : int'($urandom_range(0, 59));
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   function automatic bit rand_dir();
`ifdef TSC_DOWN_EN
      return bit'($urandom_range(0, 1));
`else
      return 1'b1;
`endif
   endfunction

   task automatic test_reset;
      clear_buttons();
      bus_if.QHM = 16'h0000;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mode_m = 0;
      n_chk += 6;
      if (bus_if.L !== 1'b0)       begin n_fail++; $display("FAIL reset L: got %b want 0", bus_if.L); end
      if (bus_if.ce_en !== 1'b1)   begin n_fail++; $display("FAIL reset ce_en: got %b want 1", bus_if.ce_en); end
      if (bus_if.DI !== 7'h00)     begin n_fail++; $display("FAIL reset DI: got %h want 00", bus_if.DI); end
      if (bus_if.H_M !== 1'b0)     begin n_fail++; $display("FAIL reset H_M: got %b want 0", bus_if.H_M); end
      if (bus_if.blink_h !== 1'b0) begin n_fail++; $display("FAIL reset blink_h: got %b want 0", bus_if.blink_h); end
      if (bus_if.blink_m !== 1'b0) begin n_fail++; $display("FAIL reset blink_m: got %b want 0", bus_if.blink_m); end
   endtask

   task automatic test_mode_blink;
      logic exp_b;
      pulse_mode();
      for (int k = 0; k < 3 * int'(BLINK_DIV); k++) begin
         if (k != 0) @(negedge clk);
         exp_b = logic'((k / int'(BLINK_DIV)) % 2);
         n_chk += 2;
         if (bus_if.blink_h !== exp_b) begin
            n_fail++;
            $display("FAIL blink_h k=%0d: got %b want %b", k, bus_if.blink_h, exp_b);
         end
         if (bus_if.blink_m !== 1'b0) begin
            n_fail++;
            $display("FAIL blink_m in set_h k=%0d: got %b want 0", k, bus_if.blink_m);
         end
      end
   endtask

   task automatic test_hours_up;
      goto_mode(1);
      press_step(8'h23, 1'b1, "h_23_up");
      press_step(8'h09, 1'b1, "h_09_up");
      press_step(8'h19, 1'b1, "h_19_up");
      // A press held into the load-wait cycle must not produce a second load.
      @(negedge clk);
      bus_if.QHM    = 16'h2359;
      bus_if.btn_up = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus_if.L !== 1'b1) begin n_fail++; $display("FAIL wait_ign first L: got %b want 1", bus_if.L); end
      @(negedge clk);
      bus_if.btn_up = 1'b0;
      n_chk++;
      if (bus_if.L !== 1'b0) begin n_fail++; $display("FAIL wait_ign second L: got %b want 0", bus_if.L); end
      for (int i = 0; i < 24; i++) press_step(rand_field(1'b1), rand_dir(), "h_rand");
   endtask

   task automatic test_minutes_up;
      goto_mode(2);
      press_step(8'h09, 1'b1, "m_09_up");
      press_step(8'h59, 1'b1, "m_59_up");
      for (int i = 0; i < 24; i++) press_step(rand_field(1'b0), rand_dir(), "m_rand");
   endtask

`ifdef TSC_DOWN_EN
   task automatic test_down;
      goto_mode(1);
      press_step(8'h00, 1'b0, "h_00_dn");
      press_step(8'h2A, 1'b1, "h_2A_up");
      press_step(8'h2A, 1'b0, "h_2A_dn");
      goto_mode(2);
      press_step(8'h00, 1'b0, "m_00_dn");
      press_step(8'h40, 1'b0, "m_40_dn");
   endtask
`endif

   task automatic test_priority;
      goto_mode(1);
      @(negedge clk);
      bus_if.QHM      = 16'h1234;
      bus_if.btn_mode = 1'b1;
      bus_if.btn_up   = 1'b1;
      @(negedge clk);
      clear_buttons();
      mode_m = 2;
      n_chk += 2;
      if (bus_if.L !== 1'b0)     begin n_fail++; $display("FAIL prio L: got %b want 0", bus_if.L); end
      if (bus_if.ce_en !== 1'b0) begin n_fail++; $display("FAIL prio ce_en: got %b want 0", bus_if.ce_en); end
      press_step(8'h34, 1'b1, "prio_then_min");
   endtask

   task automatic test_timeout;
      goto_mode(0);
      goto_mode(2);
      repeat (TIMEOUT_CYC - 1) @(negedge clk);
      n_chk++;
      if (bus_if.ce_en !== 1'b0) begin n_fail++; $display("FAIL timeout early: ce_en=%b want 0", bus_if.ce_en); end
      @(negedge clk);
      mode_m = 0;
      n_chk += 2;
      if (bus_if.ce_en !== 1'b1)   begin n_fail++; $display("FAIL timeout ce_en: got %b want 1", bus_if.ce_en); end
      if (bus_if.blink_m !== 1'b0) begin n_fail++; $display("FAIL timeout blink_m: got %b want 0", bus_if.blink_m); end
   endtask

   task automatic test_reset_mid_load;
      goto_mode(1);
      @(negedge clk);
      bus_if.QHM    = 16'h0559;
      bus_if.btn_up = 1'b1;
      @(negedge clk);
      bus_if.btn_up = 1'b0;
      n_chk++;
      if (bus_if.L !== 1'b1) begin n_fail++; $display("FAIL rst_load pre L: got %b want 1", bus_if.L); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mode_m = 0;
      n_chk += 4;
      if (bus_if.L !== 1'b0)       begin n_fail++; $display("FAIL rst_load L: got %b want 0", bus_if.L); end
      if (bus_if.ce_en !== 1'b1)   begin n_fail++; $display("FAIL rst_load ce_en: got %b want 1", bus_if.ce_en); end
      if (bus_if.blink_h !== 1'b0) begin n_fail++; $display("FAIL rst_load blink_h: got %b want 0", bus_if.blink_h); end
      if (bus_if.blink_m !== 1'b0) begin n_fail++; $display("FAIL rst_load blink_m: got %b want 0", bus_if.blink_m); end
      @(negedge clk);
      n_chk += 2;
      if (bus_if.L !== 1'b0)     begin n_fail++; $display("FAIL rst_load retry L: got %b want 0", bus_if.L); end
      if (bus_if.ce_en !== 1'b1) begin n_fail++; $display("FAIL rst_load hold ce_en: got %b want 1", bus_if.ce_en); end
   endtask

   initial begin
      clear_buttons();
      bus_if.QHM = 16'h0000;
      test_reset();
      test_mode_blink();
      test_hours_up();
      test_minutes_up();
`ifdef TSC_DOWN_EN
      test_down();
`endif
      test_priority();
      test_timeout();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-setting controller that drives the load port of the BCD hours/minutes counter (`DI`, `L`, `H_M`) and gates its count enable. It reads the counter's current time `QHM`, steps the selected field in BCD with the correct wrap (hours mod 24, minutes mod 60), and issues a single-cycle load. It sits between the debounced front-panel buttons and the clock counter. It also provides blink flags for the display driver.

## Interface
- `BLINK_DIV`, default 25_000_000: clk cycles per blink half-period.
- `TIMEOUT_CYC`, default 500_000_000: idle cycles in a set state before the block returns to RUN automatically.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `btn_mode` in 1: debounced single-cycle pulse that cycles the mode.
- `btn_up` in 1: debounced single-cycle pulse that increments the selected field.
- `btn_dn` in 1: debounced pulse that decrements the selected field. Present only with `TSC_DOWN_EN`.
- `QHM` in 16: current counter time {hours BCD, minutes BCD}.
- `DI` out 7: load data {tens[2:0], ones[3:0]}.
- `L` out 1: load strobe, one cycle wide.
- `H_M` out 1: load target; 1 = minutes, 0 = hours.
- `ce_en` out 1: count-enable gate for the counter; 1 only in RUN.
- `blink_h` out 1: hours digits are blanked this phase.
- `blink_m` out 1: minutes digits are blanked this phase.

## Operation
- **States:** RUN, SET_H, SET_M, LOAD_WAIT_H, LOAD_WAIT_M.
- **Mode sequence:** `btn_mode` moves RUN→SET_H→SET_M→RUN.
- **Step in SET_H / SET_M:**
  - On `btn_up` (or `btn_dn`), the next value is computed from the sampled field: `QHM[15:8]` for hours, `QHM[7:0]` for minutes.
  - The block registers `DI`, asserts `L` for one cycle, and drives `H_M` = 0 for hours or 1 for minutes.
  - It then enters the LOAD_WAIT state for that field.
- **LOAD_WAIT_x:** lasts exactly one cycle and ignores all buttons, so the next sample of `QHM` reflects the load. It then returns to SET_x.
- **Hours BCD step:**
  - Up: 23→00, 09→10, 19→20.
  - Down: 00→23.
  - Any invalid input (tens>2, ones>9, or >23) steps up to 00 and down to 23.
- **Minutes BCD step:**
  - Up: 59→00, x9→(x+1)0.
  - Down: 00→59.
  - Any invalid input steps up to 00 and down to 59.
- **`DI` width:** `DI[6:4]` carries the tens digit (bit 3 of the tens digit is dropped; it is always 0 for valid values).
- **`ce_en`:** 0 in all non-RUN states, so the clock is frozen while being set.
- **Blink:**
  - A counter runs 0..`BLINK_DIV`-1 and a phase bit toggles at wrap.
  - `blink_h` = phase in SET_H/LOAD_WAIT_H, else 0. `blink_m` follows the same rule for minutes.
  - The counter and phase clear on every button event, so the field is visible immediately after a press.
- **Timeout:**
  - An idle counter clears on any button pulse and on entry to a set state.
  - On reaching `TIMEOUT_CYC`-1 in SET_x, the block goes to RUN.
- **Simultaneous events:** `btn_mode` has priority over `btn_up`/`btn_dn`. With both up and down pulsing, up wins.

## Timing
- **Reset values:** state RUN, `DI`=0, `L`=0, `H_M`=0, `ce_en`=1, `blink_h`=`blink_m`=0, blink and timeout counters 0.
- **Button to load:** a press sampled at edge N produces `L`=1 with valid `DI`/`H_M` during cycle N+1. `L` returns to 0 at N+2.
- **`H_M` hold:** `H_M` holds its last value while `L`=0.
- **Mode change:** `ce_en` changes in the cycle after the `btn_mode` sample.
- **Reset mid-load:** reset asserted while `L`=1 gives `L`=0 after the next edge. No partial load is retried.
- **Timeout while loading:** a timeout never fires during LOAD_WAIT.

## Configuration
- **`TSC_DOWN_EN` defined:** the `btn_dn` port exists and decrement with the wrap rules above is active.
- **`TSC_DOWN_EN` undefined:** `btn_dn` is absent and only increment exists. All other behaviour is identical.

## Structure
- **Package `time_set_pkg`:**
  - state enum.
  - constants `HOURS_MAX`=8'h23 and `MINUTES_MAX`=8'h59.
  - field-select encodings `SEL_H`=0 and `SEL_M`=1, matching `H_M`.
- **Sub-module `bcd_step`:** combinational.
  - Inputs: 8-bit BCD value, max value, direction.
  - Output: the wrapped next value.
  - Instantiated once; its max input is muxed by state.

## Test plan
1. After reset: state RUN, `ce_en`=1, `L`=0. `btn_mode` → `ce_en`=0 one cycle later and `blink_h` starts toggling every `BLINK_DIV` cycles.
2. SET_H with `QHM`=16'h2359, `btn_up` → next cycle `L`=1, `H_M`=0, `DI`=7'h00. A second `btn_up` in the LOAD_WAIT cycle is ignored.
3. SET_M with `QHM`=16'h1209, `btn_up` → `L`=1, `H_M`=1, `DI`=7'h10. With `QHM`=16'h1259 → `DI`=7'h00.
4. `TSC_DOWN_EN`, SET_H with `QHM`=16'h0000, `btn_dn` → `DI`=7'h23. SET_M with `QHM`=16'h1000 → `DI`=7'h59. Invalid hours 8'h2A with `btn_up` → `DI`=7'h00.
5. `btn_mode` and `btn_up` in the same cycle in SET_H → state SET_M and no `L` pulse. No button for `TIMEOUT_CYC` cycles in SET_M → RUN and `ce_en`=1.
6. `rst` asserted in the cycle `L`=1 → after the edge `L`=0, state RUN, `ce_en`=1, `blink_h`=`blink_m`=0.
